// File: rtl/breath_led_scheduler.sv
// breath_led_scheduler: multi-channel breathing-LED sequencer with shared prescaler, PWM counter and duty ramp
module breath_led_scheduler #(
  parameter int LED_NUM      = 4,
  parameter int CLK_PER_STEP = 50,
  parameter int STEPS        = 1000,
  parameter int CH_W         = 2
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         cycles,
  output logic [LED_NUM-1:0] led,
  output logic               busy,
  output logic               done,
  output logic [CH_W-1:0]    cur_ch
);
  localparam int PW = CLK_PER_STEP > 1 ? $clog2(CLK_PER_STEP) : 1;
  localparam int SW = STEPS > 1 ? $clog2(STEPS) : 1;
  localparam int DW = $clog2(STEPS + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  logic [1:0]      state;
  logic            mode_q, phase_up;
  logic [7:0]      cycles_q, breath_cnt;
  logic [PW-1:0]   presc;
  logic [SW-1:0]   pwm_cnt;
  logic [DW-1:0]   duty, duty_nxt;
  logic [CH_W-1:0] ch;
  logic            tick, period_end, breath_end, last, last_ch, on, accept;
  always_comb begin
    tick       = state == S_RUN && presc == PW'(CLK_PER_STEP - 1);
    period_end = tick && pwm_cnt == SW'(STEPS - 1);
    duty_nxt   = phase_up ? duty + DW'(1) : duty - DW'(1);
    breath_end = period_end && !phase_up && duty_nxt == '0;
    last       = cycles_q != 8'd0 && breath_cnt + 8'd1 == cycles_q;
    last_ch    = ch == CH_W'(LED_NUM - 1);
    on         = DW'(pwm_cnt) < duty;
    accept     = state == S_IDLE && start && !stop;
  end
  assign busy   = state == S_RUN;
  assign done   = state == S_DONE;
  assign cur_ch = (state == S_RUN && !mode_q) ? ch : '0;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mode_q     <= 1'b0;
      cycles_q   <= '0;
      presc      <= '0;
      pwm_cnt    <= '0;
      duty       <= '0;
      phase_up   <= 1'b1;
      ch         <= '0;
      breath_cnt <= '0;
      led        <= '0;
    end else begin
      // led drops on the stop edge itself so it is dark from the first idle cycle
      led <= (state == S_RUN && !stop) ? (mode_q ? {LED_NUM{on}} : LED_NUM'(on) << ch) : '0;
      if (state != S_RUN) begin
        state      <= accept ? S_RUN : S_IDLE;
        presc      <= '0;
        pwm_cnt    <= '0;
        duty       <= '0;
        phase_up   <= 1'b1;
        ch         <= '0;
        breath_cnt <= '0;
        if (accept) begin
          mode_q   <= mode;
          cycles_q <= cycles;
        end
      end else if (stop) begin
        state <= S_IDLE;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) pwm_cnt <= period_end ? '0 : pwm_cnt + SW'(1);
        if (period_end) begin
          duty <= duty_nxt;
          if (phase_up && duty_nxt == DW'(STEPS)) phase_up <= 1'b0;
          if (breath_end) phase_up <= 1'b1;
        end
        // cycles==0 in chase advances the channel every breath and never completes
        if (breath_end) begin
          if (mode_q) begin
            if (last) state <= S_DONE;
            else breath_cnt <= breath_cnt + 8'd1;
          end else if (last && last_ch) begin
            state <= S_DONE;
          end else if (last || cycles_q == 8'd0) begin
            ch         <= last_ch ? '0 : ch + CH_W'(1);
            breath_cnt <= '0;
          end else begin
            breath_cnt <= breath_cnt + 8'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_breath_led_scheduler.sv
// tb_breath_led_scheduler: directed scenarios plus randomized runs against a time-based breathing model
module tb_breath_led_scheduler;
  localparam int LN = 4, CPS = 2, ST = 4, CW = 2;
  localparam int PER = CPS * ST, BR = 2 * ST * PER;
  logic          sys_clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [7:0]    cycles = 8'd0;
  logic [LN-1:0] led;
  logic          busy, done;
  logic [CW-1:0] cur_ch;
  int            errors = 0, checks = 0;
  always #5 sys_clk = ~sys_clk;
  breath_led_scheduler #(.LED_NUM(LN), .CLK_PER_STEP(CPS), .STEPS(ST), .CH_W(CW)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .cycles(cycles), .led(led), .busy(busy), .done(done), .cur_ch(cur_ch)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Channel breathing during clock j after the start edge
  function automatic int ref_ch(input logic m, input int c, input int j);
    if (m) return 0;
    return (c == 0) ? (j / BR) % LN : (j / BR) / c;
  endfunction
  // Drive pattern from clock j's counters: triangle duty over 2*ST periods, on while tick index < duty
  function automatic logic [LN-1:0] ref_led(input logic m, input int c, input int j);
    int w, p, q, d;
    logic [LN-1:0] one;
    w = j % BR;
    p = w / PER;
    q = (w % PER) / CPS;
    d = (p <= ST) ? p : 2 * ST - p;
    if (q >= d) return '0;
    one = 1;
    return m ? '1 : one << ref_ch(m, c, j);
  endfunction
  task automatic run_seq(input logic m, input logic [7:0] c, input int stop_at, input int len);
    int n, lim, act;
    n   = (c == 0) ? (1 << 30) : (m ? int'(c) : int'(c) * LN) * BR;
    lim = (stop_at >= 0 && stop_at < n) ? stop_at : n;
    act = (stop_at >= 0 && stop_at < n) ? stop_at + 1 : n;
    @(posedge sys_clk);
    #1 start = 1'b1; stop = 1'b0; mode = m; cycles = c;
    @(posedge sys_clk);
    for (int k = 0; k < len; k++) begin
      #1;
      start  = (k < act) ? 1'($urandom) : 1'b0;
      mode   = 1'($urandom);
      cycles = 8'($urandom);
      stop   = (k == stop_at);
      @(negedge sys_clk);
      chk("busy", 32'(busy), 32'(k < act));
      chk("done", 32'(done), 32'(k == n && act == n));
      chk("led", 32'(led), (k >= 1 && k - 1 < lim) ? 32'(ref_led(m, c, k - 1)) : 32'd0);
      chk("cur_ch", 32'(cur_ch), (k < act) ? 32'(ref_ch(m, c, k)) : 32'd0);
      @(posedge sys_clk);
    end
    #1 start = 1'b0; stop = 1'b0;
  endtask
  initial begin
    int m, c, s, len;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_led", 32'(led), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cur_ch", 32'(cur_ch), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_led", 32'(led), 0);
    run_seq(1'b0, 8'd1, -1, 4 * BR + 4);
    run_seq(1'b1, 8'd2, -1, 2 * BR + 4);
    run_seq(1'b0, 8'd0, 600, 604);
    @(posedge sys_clk);
    #1 start = 1'b1; stop = 1'b1; mode = 1'b0; cycles = 8'd1;
    @(posedge sys_clk);
    #1 start = 1'b0; stop = 1'b0;
    @(negedge sys_clk);
    chk("stop_start_busy", 32'(busy), 0);
    repeat (2) @(negedge sys_clk);
    chk("stop_start_busy2", 32'(busy), 0);
    chk("stop_start_led", 32'(led), 0);
    for (int r = 0; r < 3; r++) begin
      m = int'($urandom_range(0, 1));
      c = int'($urandom_range(0, 2));
      s = (c == 0 || $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 200)) : -1;
      len = (s >= 0) ? s + 4 : (m == 1 ? c : c * LN) * BR + 4;
      run_seq(1'(m), 8'(c), s, len);
    end
    @(posedge sys_clk);
    #1 start = 1'b1; mode = 1'b0; cycles = 8'd1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    repeat (70) @(posedge sys_clk);
    #2;
    chk("pre_rst_busy", 32'(busy), 1);
    chk("pre_rst_cur_ch", 32'(cur_ch), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_done", 32'(done), 0);
    chk("async_rst_led", 32'(led), 0);
    chk("async_rst_cur_ch", 32'(cur_ch), 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    run_seq(1'b1, 8'd1, -1, BR + 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
